seg7_scan_decoder: RTL

- Recovers hex nibbles from a multiplexed, active-low 7-segment display bus: the inverse of the team's hex-to-segment encoder.
- Samples the digit-select and segment lines and waits for each pattern to hold for a programmable number of cycles.
- Decodes each stable pattern back to its 4-bit code and keeps a per-digit shadow register.
- Used as an on-chip display monitor, so self-checking benches and scoreboards can read what is actually shown.

---
 rtl/seg7_scan_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Display monitor: recovers hex digits from a multiplexed, active-low 7-segment bus
// once each digit/segment pattern has been held for STABLE_CYC consecutive samples.
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   dig_sel_n,
  input  logic [6:0]        hex_n,
  output logic [4*NDIG-1:0] rez_all,
  output logic [NDIG-1:0]   valid,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
);

  localparam int RUN_W = $clog2(STABLE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_ACCEPT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  function automatic logic sel_legal(input logic [NDIG-1:0] sel);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!sel[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [2:0] sel_index(input logic [NDIG-1:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {hit, code}; hit=0 for blank and for any unrecognised pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [NDIG-1:0]   sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        acc_idx_q, acc_idx_d;
  logic [6:0]        acc_seg_q, acc_seg_d;
  logic [4*NDIG-1:0] rez_q, rez_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic              upd_q, upd_d;
  logic [2:0]        upd_idx_q, upd_idx_d;
  logic              err_q, err_d;
  logic              same, sel_ok;
  logic [4:0]        dec;

  always_comb begin
    sel_d  = dig_sel_n;
    seg_d  = hex_n;
    same   = (dig_sel_n == sel_q) && (hex_n == seg_q);
    sel_ok = sel_legal(sel_q);

    if (!same)                run_d = RUN_W'(1);
    else if (run_q == RUN_MAX) run_d = RUN_MAX;
    else                      run_d = run_q + 1'b1;

    state_d   = state_q;
    acc_idx_d = acc_idx_q;
    acc_seg_d = acc_seg_q;
    // The accepted pattern is latched on entry to ACCEPT so a change arriving
    // in the same cycle cannot corrupt the pending update.
    case (state_q)
      S_IDLE: begin
        if (sel_ok) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (!sel_ok) begin
          state_d = S_IDLE;
        end else if (run_q == RUN_MAX) begin
          state_d   = S_ACCEPT;
          acc_idx_d = sel_index(sel_q);
          acc_seg_d = seg_q;
        end
      end
      default: begin
        if (run_q != RUN_MAX) state_d = sel_ok ? S_TRACK : S_IDLE;
        else                  state_d = S_HOLD;
      end
    endcase

    rez_d     = rez_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    dec       = decode(~acc_seg_q);
    if (state_q == S_ACCEPT) begin
      for (int i = 0; i < NDIG; i++) begin
        if (acc_idx_q == 3'(i)) begin
          valid_d[i] = dec[4];
          if (dec[4]) begin
            rez_d[4*i +: 4] = dec[3:0];
            upd_d           = 1'b1;
            upd_idx_d       = acc_idx_q;
          end else if (acc_seg_q == 7'h7F) begin
            upd_d     = 1'b1;
            upd_idx_d = acc_idx_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '1;
      seg_q     <= 7'h7F;
      run_q     <= '0;
      state_q   <= S_IDLE;
      acc_idx_q <= 3'd0;
      acc_seg_q <= 7'h7F;
      rez_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      run_q     <= run_d;
      state_q   <= state_d;
      acc_idx_q <= acc_idx_d;
      acc_seg_q <= acc_seg_d;
      rez_q     <= rez_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      err_q     <= err_d;
    end
  end

  assign rez_all = rez_q;
  assign valid   = valid_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign err     = err_q;

endmodule
